// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32 CALC cycles per op, done pulses in the 33rd cycle.
// Divider datapath is present only when MULDIV_DIV_EN is defined; otherwise DIV/REM ops return 0.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] Rs1_data,
  input  logic [WIDTH-1:0] Rs2_data,
  input  logic [4:0]       Rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       Rd_out
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  opnd_q, hi_q, lo_q;
  logic              neg_q;
  logic [4:0]        rd_q;

  logic              accept, last;
  logic              a_signed, b_signed, a_neg, b_neg, neg_d;
  logic [WIDTH-1:0]  a_mag, b_mag, opnd_d, lo_d;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  hi_n, lo_n, res_n;
  logic [2*WIDTH-1:0] prod, prod_s;
`ifdef MULDIV_DIV_EN
  logic              div0_q, is_div, ge;
  logic [WIDTH:0]    rsh, rsh_sub;
`endif

  assign accept = start && (state_q != StCalc);
  assign last   = (state_q == StCalc) && (cnt_q == LastCnt);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state_q == StCalc);
    done = (state_q == StDone);
  end

  // Operand capture: iterate on magnitudes, remember the sign to restore at the end
  always_comb begin
    a_signed = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_signed = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    a_neg    = a_signed && Rs1_data[WIDTH-1];
    b_neg    = b_signed && Rs2_data[WIDTH-1];
    a_mag    = a_neg ? -Rs1_data : Rs1_data;
    b_mag    = b_neg ? -Rs2_data : Rs2_data;
    opnd_d   = a_mag;
    lo_d     = b_mag;
    neg_d    = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
    is_div   = funct3[2];
    if (is_div) begin
      opnd_d = b_mag;
      lo_d   = a_mag;
      // Remainder takes the dividend's sign
      neg_d  = funct3[1] ? a_neg : (a_neg ^ b_neg);
    end
`endif
  end

  // One iteration: shift-add multiply on {hi, lo}, or restoring divide (hi = rem, lo = quotient)
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rsh     = {hi_q, lo_q[WIDTH-1]};
    rsh_sub = rsh - {1'b0, opnd_q};
    ge      = (rsh >= {1'b0, opnd_q});
    if (op_q[2]) begin
      hi_n = ge ? rsh_sub[WIDTH-1:0] : rsh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end
`endif
  end

  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    res_n  = '0;
    unique case (op_q)
      3'b000:                 res_n = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res_n = prod_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         res_n = div0_q ? '1 : (neg_q ? -lo_n : lo_n);
      3'b110, 3'b111:         res_n = neg_q ? -hi_n : hi_n;
`endif
      default:                res_n = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      rd_q   <= '0;
      result <= '0;
      Rd_out <= '0;
`ifdef MULDIV_DIV_EN
      div0_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= funct3;
      opnd_q <= opnd_d;
      hi_q   <= '0;
      lo_q   <= lo_d;
      neg_q  <= neg_d;
      rd_q   <= Rd_in;
`ifdef MULDIV_DIV_EN
      div0_q <= (Rs2_data == '0);
`endif
    end else if (state_q == StCalc) begin
      cnt_q <= cnt_q + CntW'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (last) begin
        result <= res_n;
        Rd_out <= rd_q;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; 32 is the only supported value.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: Rs1_data  input  32  operand A (register file Read_data1).
REQ-007 SHALL have port: Rs2_data  input  32  operand B (register file Read_data2).
REQ-008 SHALL have port: Rd_in  input  5  destination register tag.
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result and Rd_out valid.
REQ-011 SHALL have port: result  output  32  operation result, write-data to register file.
REQ-012 SHALL have port: Rd_out  output  5  captured Rd_in tag, for register file Rd.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE/DONE with start=1: capture funct3, operands, Rd_in; go to CALC; iteration counter=0.
REQ-015 CALC: one iteration per cycle (shift-add multiply, restoring divide on magnitudes); after 32 iterations go to DONE.
REQ-016 DONE: done=1 for exactly one cycle; result and Rd_out updated on DONE entry; then IDLE, unless start=1 (REQ-014).
REQ-017 Latency SHALL be fixed: done high in the 33rd cycle after the edge sampling start, for every funct3 and operand value.
REQ-018 busy SHALL be 1 in CALC, 0 in IDLE and DONE; start while busy=1 is ignored, captured inputs unchanged.
REQ-019 result and Rd_out SHALL hold their last value until the next DONE entry.
REQ-020 MUL returns low 32 bits; MULH signed×signed, MULHSU signed A × unsigned B, MULHU unsigned×unsigned return high 32 bits of the 64-bit product.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign equals dividend sign.
REQ-022 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = Rs1_data.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-024 Operand values SHALL be used only as captured; changes on Rs1_data/Rs2_data after the start edge have no effect.
REQ-025 Rd_out=0 SHALL be passed through unchanged; write suppression for x0 remains in the register file.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, busy=0, done=0, result=0, Rd_out=0, counter=0, datapath registers 0.
REQ-027 Reset mid-operation SHALL abort it; no done pulse is produced for the aborted operation.
REQ-028 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: all eight funct3 operations implemented per REQ-020..REQ-023.
REQ-030 MULDIV_DIV_EN undefined: divider datapath absent; funct3[2]=1 ops complete with the same 33-cycle latency, result=0, Rd_out captured normally; multiply ops unchanged.

Verification
REQ-031 MUL, A=7, B=0xFFFFFFFD, Rd_in=5 -> done after 33 cycles, result=0xFFFFFFEB, Rd_out=5, busy=1 for the 32 CALC cycles.
REQ-032 MULHU, A=B=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000.
REQ-033 DIV A=0xFFFFFFF9, B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-034 DIVU A=100, B=0 -> 0xFFFFFFFF; REMU A=100, B=0 -> 100; done still at cycle 33.
REQ-035 Start MUL 3×4, pulse start with MUL 5×5 at cycle 10, drop reset at cycle 20 -> second start ignored, no done, all outputs 0; new MUL 3×4 after reset -> result 12.
REQ-036 Back-to-back: start held high through DONE -> second op accepted in DONE cycle, second done exactly 33 cycles later.
